// File: rtl/clkgen_pkg.sv
// Shared definitions for the divided-clock reset/calibration sequencer:
// the sequencer state encoding and the default cycle budgets.
package clkgen_pkg;

    // Sequencer states, in the order a normal power-up walks through them
    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        HOLD_RST   = 3'd1,
        RELEASE    = 3'd2,
        READY      = 3'd3,
        CALIB      = 3'd4,
        CAL_SETTLE = 3'd5
    } state_e;

    // Default cycle budgets, all measured in fast-clock cycles
    localparam int DEF_LOCK_CYCLES   = 64;
    localparam int DEF_RST_CYCLES    = 8;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_CALIB_CYCLES  = 2;
    localparam int DEF_CNT_W         = 8;

    // Lock-loss counter saturates here instead of wrapping
    localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

endpackage

// File: rtl/clkdiv_reset_sequencer.sv
// Sequences RESETN and CALIB of the fabric clock divider from the fast clock.
// Waits for stable PLL lock, holds the divider in reset, releases it, lets the
// divided clock settle, then serves realign requests. Loss of lock drops the
// whole sequence back to the start and is counted.
module clkdiv_reset_sequencer
    import clkgen_pkg::*;
#(
    parameter int LOCK_CYCLES   = DEF_LOCK_CYCLES,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CALIB_CYCLES  = DEF_CALIB_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       hclkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       realign_req,
    output logic       realign_ack,
    output logic       div_resetn,
    output logic       div_calib,
    output logic       div_ready,
    output logic [7:0] lock_loss_cnt
);

    // Terminal counts: the shared counter counts up from zero and each state
    // leaves when it hits its own last value, so it never wraps.
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lossCnt_q, lossCnt_d;
    logic             resetn_q, resetn_d;
    logic             calib_q, calib_d;
    logic             ready_q, ready_d;
    logic             ack_q, ack_d;

    // State, counter and registered outputs; reset returns everything to idle
    always_ff @(posedge hclkin) begin
        if (reset) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            lossCnt_q <= '0;
            resetn_q  <= 1'b0;
            calib_q   <= 1'b0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lossCnt_q <= lossCnt_d;
            resetn_q  <= resetn_d;
            calib_q   <= calib_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
        end
    end

    // Next state and counter; loss of lock outside WAIT_LOCK overrides all else
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lossCnt_d = lossCnt_q;

        if (state_q != WAIT_LOCK && !pll_lock) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            if (lossCnt_q != LOSS_CNT_MAX) begin
                lossCnt_d = lossCnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!pll_lock) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = HOLD_RST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY: begin
                    if (realign_req) begin
                        state_d = CALIB;
                        cnt_d   = '0;
                    end
                end
                CALIB: begin
                    if (cnt_q == CALIB_LAST) begin
                        state_d = CAL_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CAL_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the transition being taken so they change on
    // the same edge as the state. Ready only shows while READY is held, so it
    // drops on the edge that leaves READY and stays low during the ack cycle.
    always_comb begin
        resetn_d = 1'b1;
        calib_d  = 1'b0;
        ready_d  = 1'b0;
        ack_d    = 1'b0;
        if (state_d == WAIT_LOCK || state_d == HOLD_RST) begin
            resetn_d = 1'b0;
        end
        if (state_d == CALIB) begin
            calib_d = 1'b1;
        end
        if (state_q == READY && state_d == READY) begin
            ready_d = 1'b1;
        end
        if (state_q == CAL_SETTLE && state_d == READY) begin
            ack_d = 1'b1;
        end
    end

    assign realign_ack   = ack_q;
    assign div_resetn    = resetn_q;
    assign div_calib     = calib_q;
    assign div_ready     = ready_q;
    assign lock_loss_cnt = lossCnt_q;

endmodule
